// File: rtl/chi5pc_sam_remap_unit.sv
// System address map remapper: a two-stage pipeline that routes each request
// by opcode bypass, programmable address regions or an HN-F hash.
module chi5pc_sam_remap_unit #(
    parameter int ADDR_WIDTH   = 44,
    parameter int TGTID_WIDTH  = 7,
    parameter int OPCODE_WIDTH = 6,
    parameter int NUM_REGIONS  = 8,
    parameter int NUM_HNF      = 4,
    parameter logic [OPCODE_WIDTH-1:0] OP_EOBARRIER = 6'h0E,
    parameter logic [OPCODE_WIDTH-1:0] OP_ECBARRIER = 6'h0C,
    parameter logic [OPCODE_WIDTH-1:0] OP_DVMOP     = 6'h14
) (
    input  logic                    SCLK,
    input  logic                    SRESETn,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [OPCODE_WIDTH-1:0] REQ_OPCODE,
    input  logic [TGTID_WIDTH-1:0]  REQ_TGTID,
    output logic                    RMP_VALID,
    input  logic                    RMP_READY,
    output logic [TGTID_WIDTH-1:0]  RMP_TGTID,
    output logic [TGTID_WIDTH-1:0]  RMP_ORIG_TGTID,
    output logic                    RMP_HIT,
    output logic                    RMP_BYPASS,
    output logic                    RMP_MISMATCH,
    input  logic                    CFG_RGN_WE,
    input  logic [3:0]              CFG_RGN_IDX,
    input  logic                    CFG_RGN_EN,
    input  logic                    CFG_RGN_HASH,
    input  logic [ADDR_WIDTH-1:0]   CFG_RGN_BASE,
    input  logic [ADDR_WIDTH-1:0]   CFG_RGN_MASK,
    input  logic [TGTID_WIDTH-1:0]  CFG_RGN_TGTID,
    input  logic                    CFG_HNF_WE,
    input  logic [3:0]              CFG_HNF_IDX,
    input  logic [TGTID_WIDTH-1:0]  CFG_HNF_TGTID,
    input  logic                    CFG_CNT_CLR,
    output logic [15:0]             MISMATCH_CNT
);
    localparam int HB     = (NUM_HNF > 1) ? $clog2(NUM_HNF) : 1;
    localparam int FOLD_W = ADDR_WIDTH - 6;

    logic                   rgn_en_q   [NUM_REGIONS], rgn_en_d   [NUM_REGIONS];
    logic                   rgn_hash_q [NUM_REGIONS], rgn_hash_d [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  rgn_base_q [NUM_REGIONS], rgn_base_d [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  rgn_mask_q [NUM_REGIONS], rgn_mask_d [NUM_REGIONS];
    logic [TGTID_WIDTH-1:0] rgn_tgt_q  [NUM_REGIONS], rgn_tgt_d  [NUM_REGIONS];
    logic [TGTID_WIDTH-1:0] hnf_q      [NUM_HNF],     hnf_d      [NUM_HNF];

    logic                   s1_valid_q, s1_valid_d, s1_bypass_q, s1_bypass_d;
    logic                   s1_hit_q, s1_hit_d, s1_hash_q, s1_hash_d;
    logic [TGTID_WIDTH-1:0] s1_tgt_q, s1_tgt_d, s1_orig_q, s1_orig_d;
    logic [HB-1:0]          s1_hidx_q, s1_hidx_d;
    logic [TGTID_WIDTH-1:0] s1_hnf_q [NUM_HNF], s1_hnf_d [NUM_HNF];

    logic                   s2_valid_q, s2_valid_d, rmp_hit_q, rmp_hit_d;
    logic                   rmp_bypass_q, rmp_bypass_d;
    logic [TGTID_WIDTH-1:0] rmp_tgt_q, rmp_tgt_d, rmp_orig_q, rmp_orig_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   s1_load, s2_load, bypass, rgn_hit, rgn_hash;
    logic [TGTID_WIDTH-1:0] rgn_tgt, hnf_sel;
    logic [HB-1:0]          hidx;

    assign s2_load   = !s2_valid_q || RMP_READY;
    assign s1_load   = !s1_valid_q || s2_load;
    assign REQ_READY = s1_load;
    assign bypass    = (REQ_OPCODE == OP_EOBARRIER) || (REQ_OPCODE == OP_ECBARRIER)
                    || (REQ_OPCODE == OP_DVMOP);

    // Walk from the top index down so the lowest matching region wins.
    always_comb begin
        rgn_hit  = 1'b0;
        rgn_hash = 1'b0;
        rgn_tgt  = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (rgn_en_q[r] && ((REQ_ADDR & rgn_mask_q[r]) == (rgn_base_q[r] & rgn_mask_q[r]))) begin
                rgn_hit  = 1'b1;
                rgn_hash = rgn_hash_q[r];
                rgn_tgt  = rgn_tgt_q[r];
            end
        end
    end

    always_comb begin
        hidx = '0;
        if (NUM_HNF > 1) begin
            for (int i = 0; i < FOLD_W; i++) hidx[i % HB] = hidx[i % HB] ^ REQ_ADDR[6 + i];
        end
    end

    always_comb begin
        rgn_en_d   = rgn_en_q;
        rgn_hash_d = rgn_hash_q;
        rgn_base_d = rgn_base_q;
        rgn_mask_d = rgn_mask_q;
        rgn_tgt_d  = rgn_tgt_q;
        hnf_d      = hnf_q;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (CFG_RGN_WE && (CFG_RGN_IDX == 4'(r))) begin
                rgn_en_d[r]   = CFG_RGN_EN;
                rgn_hash_d[r] = CFG_RGN_HASH;
                rgn_base_d[r] = CFG_RGN_BASE;
                rgn_mask_d[r] = CFG_RGN_MASK;
                rgn_tgt_d[r]  = CFG_RGN_TGTID;
            end
        end
        for (int i = 0; i < NUM_HNF; i++) begin
            if (CFG_HNF_WE && (CFG_HNF_IDX == 4'(i))) hnf_d[i] = CFG_HNF_TGTID;
        end
    end

    // S1 keeps a private copy of the hash table so later HNF writes cannot reach it.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_hit_d    = s1_hit_q;
        s1_hash_d   = s1_hash_q;
        s1_tgt_d    = s1_tgt_q;
        s1_orig_d   = s1_orig_q;
        s1_hidx_d   = s1_hidx_q;
        s1_hnf_d    = s1_hnf_q;
        if (s1_load) begin
            s1_valid_d = REQ_VALID;
            if (REQ_VALID) begin
                s1_bypass_d = bypass;
                s1_hit_d    = rgn_hit && !bypass;
                s1_hash_d   = rgn_hit && !bypass && rgn_hash;
                s1_tgt_d    = (rgn_hit && !bypass) ? rgn_tgt : REQ_TGTID;
                s1_orig_d   = REQ_TGTID;
                s1_hidx_d   = hidx;
                s1_hnf_d    = hnf_q;
            end
        end
    end

    always_comb begin
        hnf_sel = '0;
        for (int i = 0; i < NUM_HNF; i++) begin
            if (s1_hidx_q == HB'(i)) hnf_sel = s1_hnf_q[i];
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        rmp_hit_d    = rmp_hit_q;
        rmp_bypass_d = rmp_bypass_q;
        rmp_tgt_d    = rmp_tgt_q;
        rmp_orig_d   = rmp_orig_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rmp_hit_d    = s1_hit_q;
                rmp_bypass_d = s1_bypass_q;
                rmp_tgt_d    = s1_hash_q ? hnf_sel : s1_tgt_q;
                rmp_orig_d   = s1_orig_q;
            end
        end
    end

    assign RMP_VALID      = s2_valid_q;
    assign RMP_TGTID      = rmp_tgt_q;
    assign RMP_ORIG_TGTID = rmp_orig_q;
    assign RMP_HIT        = rmp_hit_q;
    assign RMP_BYPASS     = rmp_bypass_q;
    assign RMP_MISMATCH   = (rmp_tgt_q != rmp_orig_q) && !rmp_bypass_q;
    assign MISMATCH_CNT   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (CFG_CNT_CLR) cnt_d = '0;
        else if (s2_valid_q && RMP_READY && RMP_MISMATCH && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge SCLK or negedge SRESETn) begin
        if (!SRESETn) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                rgn_en_q[r]   <= 1'b0;
                rgn_hash_q[r] <= 1'b0;
                rgn_base_q[r] <= '0;
                rgn_mask_q[r] <= '0;
                rgn_tgt_q[r]  <= '0;
            end
            for (int i = 0; i < NUM_HNF; i++) begin
                hnf_q[i]    <= '0;
                s1_hnf_q[i] <= '0;
            end
            s1_valid_q   <= 1'b0;
            s1_bypass_q  <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_hash_q    <= 1'b0;
            s1_tgt_q     <= '0;
            s1_orig_q    <= '0;
            s1_hidx_q    <= '0;
            s2_valid_q   <= 1'b0;
            rmp_hit_q    <= 1'b0;
            rmp_bypass_q <= 1'b0;
            rmp_tgt_q    <= '0;
            rmp_orig_q   <= '0;
            cnt_q        <= '0;
        end else begin
            rgn_en_q     <= rgn_en_d;
            rgn_hash_q   <= rgn_hash_d;
            rgn_base_q   <= rgn_base_d;
            rgn_mask_q   <= rgn_mask_d;
            rgn_tgt_q    <= rgn_tgt_d;
            hnf_q        <= hnf_d;
            s1_hnf_q     <= s1_hnf_d;
            s1_valid_q   <= s1_valid_d;
            s1_bypass_q  <= s1_bypass_d;
            s1_hit_q     <= s1_hit_d;
            s1_hash_q    <= s1_hash_d;
            s1_tgt_q     <= s1_tgt_d;
            s1_orig_q    <= s1_orig_d;
            s1_hidx_q    <= s1_hidx_d;
            s2_valid_q   <= s2_valid_d;
            rmp_hit_q    <= rmp_hit_d;
            rmp_bypass_q <= rmp_bypass_d;
            rmp_tgt_q    <= rmp_tgt_d;
            rmp_orig_q   <= rmp_orig_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: doc/chi5pc_sam_remap_unit.md
CHI5PC_SAM_REMAP_UNIT -- requirements
Module: chi5pc_sam_remap_unit

Interface
REQ-001 The block SHALL have the following parameters, given as name, default and meaning:
- ADDR_WIDTH, 44, request address width.
- TGTID_WIDTH, 7, node ID width.
- OPCODE_WIDTH, 6, opcode width.
- NUM_REGIONS, 8, number of programmable address regions (1..16).
- NUM_HNF, 4, number of HN-F hash targets (power of 2, 1..16).
- OP_EOBARRIER, 6'h0E, EOBarrier opcode value.
- OP_ECBARRIER, 6'h0C, ECBarrier opcode value.
- OP_DVMOP, 6'h14, DVMOp opcode value.

REQ-002 The block SHALL have the following ports, given as name, direction, width and meaning:
- SCLK, in, 1, the single clock.
- SRESETn, in, 1, reset, asynchronous and active-low.
- REQ_VALID, in, 1, request flit valid.
- REQ_READY, out, 1, request accepted.
- REQ_ADDR, in, ADDR_WIDTH, request address.
- REQ_OPCODE, in, OPCODE_WIDTH, request opcode.
- REQ_TGTID, in, TGTID_WIDTH, TgtID carried in the flit.
- RMP_VALID, out, 1, remap result valid.
- RMP_READY, in, 1, downstream accepts the result.
- RMP_TGTID, out, TGTID_WIDTH, remapped target ID.
- RMP_ORIG_TGTID, out, TGTID_WIDTH, flit TgtID carried through.
- RMP_HIT, out, 1, a region matched.
- RMP_BYPASS, out, 1, opcode-routed (barrier or DVM).
- RMP_MISMATCH, out, 1, the result differs from the flit TgtID.
- CFG_RGN_WE, in, 1, region write strobe.
- CFG_RGN_IDX, in, 4, region index.
- CFG_RGN_EN, in, 1, region enable.
- CFG_RGN_HASH, in, 1, region uses the HN-F hash.
- CFG_RGN_BASE, in, ADDR_WIDTH, region base.
- CFG_RGN_MASK, in, ADDR_WIDTH, region compare mask.
- CFG_RGN_TGTID, in, TGTID_WIDTH, region target.
- CFG_HNF_WE, in, 1, hash-table write strobe.
- CFG_HNF_IDX, in, 4, hash-table index.
- CFG_HNF_TGTID, in, TGTID_WIDTH, hash-table entry.
- CFG_CNT_CLR, in, 1, clear the mismatch counter.
- MISMATCH_CNT, out, 16, saturating mismatch count.

Function
REQ-003 The block SHALL be a 2-stage pipeline (S1 register, S2 output register); a request accepted at edge N SHALL present RMP_VALID=1 after edge N+1 when not stalled.
REQ-004 S2 SHALL load when !S2_valid || RMP_READY; S1 SHALL load when !S1_valid || S2 loads; REQ_READY SHALL equal the S1 load condition (combinational).
REQ-005 While RMP_VALID=1 && RMP_READY=0, all RMP_* outputs SHALL hold stable.
REQ-006 Bypass: if REQ_OPCODE equals OP_EOBARRIER, OP_ECBARRIER or OP_DVMOP, then RMP_BYPASS=1, RMP_HIT=0 and RMP_TGTID=REQ_TGTID.
REQ-007 Region r SHALL match when it is enabled and (REQ_ADDR & MASK[r]) == (BASE[r] & MASK[r]); the lowest matching index wins.
REQ-008 On a hit with HASH=0, RMP_TGTID SHALL be TGTID[r]; with HASH=1, RMP_TGTID SHALL be HNF[h].
- h is the XOR-fold of REQ_ADDR[ADDR_WIDTH-1:6] into log2(NUM_HNF)-bit chunks.
- The top chunk is zero-padded.
- When NUM_HNF=1, h=0.
REQ-009 On no hit and no bypass, RMP_TGTID SHALL be REQ_TGTID and RMP_HIT SHALL be 0 (pass-through default).
REQ-010 Region match, selected TGTID/HASH and the hash index SHALL be evaluated on the input and captured into S1 at acceptance; S2 SHALL resolve the HNF table.
REQ-011 Configuration snapshot:
- A CFG write at edge N SHALL affect only requests accepted at edge N+1 or later.
- Requests already in S1/S2 SHALL be unaffected, including by HNF writes; S1 captures the HNF entry index and S2 reads a table copy latched at acceptance.
REQ-012 Out-of-range CFG_RGN_IDX (>= NUM_REGIONS) or CFG_HNF_IDX (>= NUM_HNF) writes SHALL be ignored.
REQ-013 RMP_MISMATCH SHALL be (RMP_TGTID != RMP_ORIG_TGTID) && !RMP_BYPASS.
REQ-014 MISMATCH_CNT SHALL increment on each RMP_VALID && RMP_READY && RMP_MISMATCH and saturate at 16'hFFFF.
- CFG_CNT_CLR sets it to 0 and wins over a simultaneous increment.

Reset
REQ-015 SRESETn low SHALL asynchronously clear the following:
- S1_valid, S2_valid and RMP_VALID.
- All region EN bits, BASE/MASK/TGTID, and the HNF table (to 0).
- MISMATCH_CNT.
- All RMP_* data outputs (to 0).
REQ-016 REQ_READY SHALL be 1 throughout reset and after its release; in-flight requests during reset SHALL be discarded, not emitted.
REQ-017 Deassertion SHALL be synchronised by the integrator; the block SHALL accept a request on the first edge after SRESETn rises.

Verification
REQ-018 Fresh reset, REQ addr 0x1000, opcode ReadShared (0x01), TGTID 5 -> 2 cycles later RMP_TGTID=5, HIT=0, MISMATCH=0, CNT=0.
REQ-019 Regions 0 and 1 both cover 0x8000_0000 (TGTID 3 and 9), request at that address with flit TGTID 9 -> RMP_TGTID=3, HIT=1, MISMATCH=1, CNT=1 after handshake.
REQ-020 Region 0 HASH=1, NUM_HNF=4, HNF={0x10,0x11,0x12,0x13}, addr 0x40 -> h=1 -> RMP_TGTID=0x11; addr 0xC0 -> h=3 -> RMP_TGTID=0x13.
REQ-021 DVMOp (0x14) with flit TGTID 0x20 at an address matching region 0 -> RMP_TGTID=0x20, BYPASS=1, HIT=0, CNT unchanged.
REQ-022 Backpressure:
- Stimulus: RMP_READY=0 for 5 cycles while 3 requests are offered.
- Required: exactly 2 accepted (S1+S2 full), REQ_READY=0, outputs stable.
- On RMP_READY=1, results emerge in order with no loss or duplication.
REQ-023 Counter and config races:
- Preload CNT=16'hFFFF via forced mismatches -> one further mismatch leaves 16'hFFFF.
- CFG_CNT_CLR coinciding with a mismatch handshake -> CNT=0.
- Region 0 TGTID rewritten while a request sits stalled in S1 -> that request still reports the old TGTID.
